// File: rtl/cska_pkg.sv
// Shared types and default sizing for the sequential carry-skip subtractor.
package cska_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int BLK_DEF   = 4;
    localparam int NBLK      = WIDTH_DEF / BLK_DEF;
    localparam int IDX_W     = $clog2(NBLK);

    // Block index width for an arbitrary block count, never narrower than 1 bit.
    function automatic int idx_w(input int nblk);
        return (nblk > 1) ? $clog2(nblk) : 1;
    endfunction

endpackage

// File: rtl/cska_sub_blk.sv
// One carry-skip block: BLK-bit ripple adder plus propagate detect and skip mux.
module cska_sub_blk
    import cska_pkg::*;
#(
    parameter int BLK = BLK_DEF
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b_n,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout_sel,
    output logic           skip
);

    logic [BLK:0]   w_c;
    logic [BLK-1:0] w_p;

    assign w_c[0] = cin;

    for (genvar i = 0; i < BLK; i++) begin : g_rip
        assign w_p[i]   = a[i] ^ b_n[i];
        assign sum[i]   = w_p[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b_n[i]) | (w_c[i] & w_p[i]);
    end

    // All bits propagate: the incoming carry passes straight through.
    assign skip     = &w_p;
    assign cout_sel = skip ? cin : w_c[BLK];

endmodule

// File: rtl/cska_sub_seq.sv
// Sequential carry-skip subtractor: one BLK-bit block per cycle, a - b - bin.
module cska_sub_seq
    import cska_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLK   = BLK_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH:0]        d,
    output logic [WIDTH/BLK-1:0]  skip_mask
);

    localparam int L_NBLK = WIDTH / BLK;
    localparam int L_IDXW = idx_w(L_NBLK);

    state_t                r_state, w_nxt;
    logic [WIDTH-1:0]      r_a, r_bn;
    logic                  r_carry;
    logic [L_IDXW-1:0]     r_idx;
    logic [WIDTH:0]        r_d;
    logic [L_NBLK-1:0]     r_skip;

    logic [BLK-1:0]        w_a_sl, w_bn_sl, w_sum;
    logic                  w_cout, w_skip, w_last, w_accept;

    assign w_a_sl   = r_a[r_idx*BLK +: BLK];
    assign w_bn_sl  = r_bn[r_idx*BLK +: BLK];
    assign w_last   = (r_idx == L_IDXW'(L_NBLK - 1));
    assign w_accept = (r_state == IDLE) && in_valid;

    cska_sub_blk #(.BLK(BLK)) u_blk (
        .a        (w_a_sl),
        .b_n      (w_bn_sl),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout_sel (w_cout),
        .skip     (w_skip)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_nxt     = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    // Operand capture and per-block datapath; the subtrahend is stored inverted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_bn    <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_d     <= '0;
            r_skip  <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_bn    <= ~b;
            r_carry <= ~bin;
            r_idx   <= '0;
            r_d     <= '0;
            r_skip  <= '0;
        end else if (r_state == RUN) begin
            r_d[r_idx*BLK +: BLK] <= w_sum;
            r_skip[r_idx]         <= w_skip;
            r_carry               <= w_cout;
            r_idx                 <= r_idx + 1'b1;
            if (w_last) r_d[WIDTH] <= ~w_cout;
        end
    end

    assign d         = r_d;
    assign skip_mask = r_skip;

endmodule

// File: tb/tb_cska_sub_seq.sv
// Randomized self-checking bench for cska_sub_seq against an arithmetic model.
module tb_cska_sub_seq;

    localparam int W   = 16;
    localparam int BLK = 4;
    localparam int NB  = W / BLK;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          bin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W:0]    d;
    logic [NB-1:0] skip_mask;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cska_sub_seq #(.WIDTH(W), .BLK(BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .skip_mask (skip_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic in W+1 bits leaves the borrow in the top bit.
    function automatic logic [W:0] ref_d(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        return {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    endfunction

    // A block skips exactly when the operand slices are identical.
    function automatic logic [NB-1:0] ref_skip(input logic [W-1:0] ta, input logic [W-1:0] tb);
        logic [NB-1:0] m;
        for (int k = 0; k < NB; k++) m[k] = ((ta >> (k*BLK)) & 4'hF) == ((tb >> (k*BLK)) & 4'hF);
        return m;
    endfunction

    // Full transaction: accept, check latency/result, stall in DONE, drain.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input int stall, input bit rel);
        logic [W:0] exp_d;
        int cyc;
        exp_d = ref_d(ta, tb, tbin);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, NB);
        chk("d", {15'd0, d}, {15'd0, exp_d});
        chk("skip", {28'd0, skip_mask}, {28'd0, ref_skip(ta, tb)});
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_d", {15'd0, d}, {15'd0, exp_d});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int stall;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", {15'd0, d}, 32'd0);
        chk("rst_skip", {28'd0, skip_mask}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // First acceptance on the first edge after release.
        do_op(16'h1234, 16'h0234, 1'b0, 0, 1'b1);
        chk("dir_1234", {15'd0, d}, 32'h0_1000);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
        // Ten-cycle DONE hold with in_valid high; next op accepted one cycle after drain.
        do_op(16'h8000, 16'h7FFF, 1'b1, 10, 1'b0);
        do_op(16'h0001, 16'h0000, 1'b1, 0, 1'b0);

        // Reset two cycles into RUN aborts the operation.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("abort_run_ov", {31'd0, out_valid}, 32'd0);
        chk("abort_run_d", {15'd0, d}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_run_no_ov", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h4321, 16'h1234, 1'b1, 2, 1'b1);

        // Reset while holding a result in DONE.
        @(negedge clk);
        a = 16'h0F0F; b = 16'h00FF; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (NB) @(posedge clk);
        #1;
        chk("pre_abort_ov", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0; #1;
        chk("abort_done_ov", {31'd0, out_valid}, 32'd0);
        chk("abort_done_d", {15'd0, d}, 32'd0);
        do_op(16'h0F0F, 16'h00FF, 1'b0, 0, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            // Bias some operands so equal slices (skip path) appear often.
            if ($urandom_range(0, 3) == 0) rb = ra ^ W'(16'h000F << (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) rb = ra;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_op(ra, rb, 1'($urandom), stall, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cska_sub_seq.md
CSKA_SUB_SEQ -- requirements
Module: cska_sub_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of BLK.
REQ-002 Parameter BLK, default 4: block width in bits; one block is processed per cycle.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operands a, b and bin are valid.
REQ-006 in_ready  output  1  block accepts new operands; SHALL be high only in IDLE.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  d and skip_mask hold the result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 d  output  WIDTH+1  d[WIDTH-1:0] is the difference; d[WIDTH] is the borrow-out.
REQ-013 skip_mask  output  WIDTH/BLK  bit k is set when block k's outgoing carry came from the skip path.

Function
REQ-014 The block SHALL compute a - b - bin as a + ~b + ~bin, with borrow-out = ~carry-out.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on in_valid && in_ready.
REQ-017 On that transition the block SHALL capture a, b and ~bin (as the carry), and SHALL clear blk_idx, d and skip_mask.
REQ-018 In RUN, each cycle SHALL process block blk_idx:
 - a 4-bit ripple sum on a-slice, ~b-slice and the registered carry, written to d;
 - propagate P = AND over the slice of (a ^ ~b);
 - next carry = P ? incoming carry : ripple cout;
 - skip_mask[blk_idx] = P.
REQ-019 blk_idx SHALL increment each RUN cycle; RUN -> DONE after the block with blk_idx = WIDTH/BLK-1.
REQ-020 On entry to DONE, d[WIDTH] SHALL be loaded with the inverted final carry.
REQ-021 Latency: for an acceptance on edge E0, out_valid SHALL rise after edge E0+WIDTH/BLK (4 cycles at default parameters).
REQ-022 In DONE, out_valid SHALL be 1, and d and skip_mask SHALL be held stable until out_ready.
REQ-023 DONE -> IDLE on the edge where out_ready=1.
REQ-024 The earliest next acceptance SHALL be one cycle after that edge; there is no overlap of operations.
REQ-025 Inputs a, b and bin SHALL be ignored outside the acceptance edge; changes during RUN SHALL have no effect.
REQ-026 in_valid while busy SHALL be stalled: in_ready=0, and no capture.
REQ-027 out_ready while not in DONE SHALL be ignored.
REQ-028 Results SHALL be bit-exact to (a - b - bin) mod 2^WIDTH.
REQ-029 Borrow-out SHALL be 1 exactly when a < b + bin (unsigned).

Reset
REQ-030 rst_n low SHALL asynchronously force:
 - state = IDLE, blk_idx = 0, carry = 0;
 - d = 0, skip_mask = 0, out_valid = 0, in_ready = 1 after release.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse.
REQ-032 The first acceptance SHALL be possible on the first edge after release.

Structure
REQ-033 A shared package cska_pkg SHALL hold:
 - the state enum {IDLE, RUN, DONE};
 - WIDTH/BLK defaults;
 - the NBLK = WIDTH/BLK constant;
 - the blk_idx width $clog2(NBLK).
REQ-034 One combinational sub-module cska_sub_blk (BLK-bit ripple plus propagate/skip mux, outputs sum, cout_sel, skip) SHALL be instantiated once and time-multiplexed.
REQ-035 No latches or tri-state primitives; the skip mux SHALL be a plain 2:1 select.

Verification
REQ-036 a=0x1234, b=0x0234, bin=0 -> out_valid 4 cycles after accept; d=0x0_1000.
REQ-037 a=0x0000, b=0x0001, bin=0 -> d=0x1_FFFF (borrow 1).
REQ-038 a=0xFFFF, b=0xFFFF, bin=1 -> d=0x1_FFFF, skip_mask=4'hF; with bin=0 -> d=0x0_0000, skip_mask=4'hF.
REQ-039 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and changing a/b:
 - d stays constant;
 - in_ready stays 0;
 - after out_ready=1, the next accept happens one cycle later.
REQ-040 Assert rst_n low two cycles after acceptance -> out_valid=0, d=0 immediately; a new op after release completes correctly.
REQ-041 10k random (a, b, bin) with random out_ready stalls -> every result matches the reference model; skip_mask[k] equals (a_k == b_k) for each block.
